// File: rtl/score_scan_driver.sv
// Binary score -> 4 BCD digits (sequential double-dabble) + multiplexed nibble/anode scan driver.
// Optional: define SCORE_BLANK_LEADING_EN to blank leading-zero digit slots (ones digit always lit).

module score_dabble_col (
  input  logic [3:0] col,
  output logic [3:0] adj
);
  assign adj = (col >= 4'd5) ? col + 4'd3 : col;
endmodule

module score_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] score,
  input  logic        load,
  output logic        busy,
  output logic [3:0]  digit,
  output logic [3:0]  an
);
  localparam int NUM_COLS = 4;
  localparam int CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                      state;
  logic [29:0]                 sr;    // {bcd[15:0], bin[13:0]}
  logic [3:0]                  iter;
  logic [15:0]                 bcd;
  logic [NUM_COLS-1:0][3:0]    cols, adj;
  logic [29:0]                 sr_nxt;
  logic [13:0]                 sat;

  assign cols = sr[29:14];

  genvar g;
  generate
    for (g = 0; g < NUM_COLS; g++) begin : g_col
      score_dabble_col u_col (.col(cols[g]), .adj(adj[g]));
    end
  endgenerate

  assign sr_nxt = {adj[3:0], sr[13:0]} << 1;
  assign sat    = (score > 14'd9999) ? 14'd9999 : score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      iter  <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          sr    <= {16'h0000, sat};
          iter  <= '0;
          busy  <= 1'b1;
          state <= CONV;
        end
        CONV: begin
          sr   <= sr_nxt;
          iter <= iter + 4'd1;
          if (iter == 4'd13) state <= COMMIT;
        end
        COMMIT: begin
          bcd   <= sr[29:14];
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan engine: outputs are driven from the next index so they switch on the wrap edge.
  logic [CW-1:0] cnt;
  logic [1:0]    idx, idx_nxt;
  logic          wrap;
  logic          blank;

  assign wrap    = (cnt == CW'(SCAN_DIV - 1));
  assign idx_nxt = wrap ? idx + 2'd1 : idx;

`ifdef SCORE_BLANK_LEADING_EN
  logic [3:0] lz;
  always_comb begin
    lz    = '0;
    lz[3] = (bcd[15:12] == 4'd0);
    lz[2] = lz[3] && (bcd[11:8] == 4'd0);
    lz[1] = lz[2] && (bcd[7:4] == 4'd0);
    blank = lz[idx_nxt];
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      digit <= '0;
      an    <= 4'b1110;
    end else begin
      cnt   <= wrap ? '0 : cnt + 1'b1;
      idx   <= idx_nxt;
      digit <= bcd[{idx_nxt, 2'b00} +: 4];
      an    <= blank ? 4'b1111 : ~(4'b0001 << idx_nxt);
    end
  end
endmodule

// File: tb/tb_score_scan_driver.sv
// Scoreboard bench for score_scan_driver: loads push expected BCD, a monitor checks on each busy fall.
module tb_score_scan_driver;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] score = '0;
  logic        load = 1'b0;
  logic        busy;
  logic [3:0]  digit, an;

  int checks = 0;
  int errors = 0;
  logic [15:0] expq[$];
  bit mon_active = 0;

  score_scan_driver #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .score(score), .load(load),
    .busy(busy), .digit(digit), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_an(input logic [15:0] b, input int k);
    logic [3:0] a;
    a = ~(4'b0001 << k);
`ifdef SCORE_BLANK_LEADING_EN
    if (k == 3 && b[15:12] == 0) a = 4'b1111;
    if (k == 2 && b[15:8]  == 0) a = 4'b1111;
    if (k == 1 && b[15:4]  == 0) a = 4'b1111;
`endif
    return a;
  endfunction

  // Align to the start of the ones slot, then sample each slot one cycle in.
  task automatic check_frame(input logic [15:0] b);
    logic [3:0] prev;
    int n, found;
    prev = an; n = 0; found = 0;
    while (!found && n < 4*SD + 4) begin
      @(negedge clk); n++;
      if (an == 4'b1110 && prev != 4'b1110) found = 1;
      else prev = an;
    end
    chk("frame_align", found, 1);
    if (found) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (k > 0) repeat (SD) @(negedge clk);
        chk($sformatf("an_slot%0d_%04h", k, b), an, exp_an(b, k));
        chk($sformatf("digit_slot%0d_%04h", k, b), digit, b[k*4 +: 4]);
      end
    end
  endtask

  // Monitor
  initial begin
    int hc;
    logic pb;
    logic [15:0] e;
    hc = 0; pb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hc = 0; pb = 0;
      end else begin
        if (busy) hc++;
        else if (pb) begin
          mon_active = 1;
          if (expq.size() == 0) chk("unexpected_conversion", 1, 0);
          else begin
            e = expq.pop_front();
            chk($sformatf("busy_cycles_%04h", e), hc, 15);
            check_frame(e);
          end
          hc = 0;
          mon_active = 0;
        end
        pb = busy;
      end
    end
  end

  task automatic do_load(input logic [13:0] s, input logic [15:0] e, input bit push);
    @(negedge clk);
    score = s; load = 1'b1;
    if (push) expq.push_back(e);
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (busy && n < 60) begin @(negedge clk); n++; end
    chk("busy_timeout", busy, 0);
    repeat (8*SD + 10) @(negedge clk);
    chk("monitor_idle", mon_active, 0);
  endtask

  initial begin
    logic [3:0] acc;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Reset mid-frame, asynchronous effect, first advance timing
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_an", an, 4'b1110);
    chk("rst_digit", digit, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("pre_advance_an", an, 4'b1110);
    @(posedge clk);
    #1 chk("first_advance_an", an, 4'b1101);

    do_load(14'd1234,  16'h1234, 1); settle();
    do_load(14'd12000, 16'h9999, 1); settle();
    do_load(14'd9999,  16'h9999, 1); settle();
    do_load(14'd0,     16'h0000, 1); settle();

    // Busy collision: second load three cycles later is ignored
    do_load(14'd42, 16'h0042, 1);
    repeat (2) @(posedge clk);
    do_load(14'd777, 16'h0777, 0);
    settle();
    do_load(14'd777, 16'h0777, 1); settle();

    // Reset mid-conversion
    do_load(14'd5678, 16'h5678, 0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midconv_busy", busy, 0);
    chk("midconv_an", an, 4'b1110);
    chk("midconv_digit", digit, 0);
    @(negedge clk); #2 rst = 1'b0;
    acc = '0;
    repeat (4*SD + 2) begin @(negedge clk); acc = acc | digit; end
    chk("midconv_bcd_zero", acc, 0);
    chk("midconv_busy_after", busy, 0);
    do_load(14'd5678, 16'h5678, 1); settle();

    do_load(14'd7,    16'h0007, 1); settle();
    do_load(14'd1005, 16'h1005, 1); settle();

    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
